regfile_sb: RTL

Parametrised integer register file with a per-register scoreboard, used by the tiny5 decode/issue stage in place of the fixed two-read, one-write register file. It provides NRD combinational read ports, one write port with optional write-to-read bypass, and a busy bit per register. Issue claims a destination register, and writeback releases it. Register 0 is hardwired to zero and is never busy.

---
 rtl/regfile_sb.sv | 59 +++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register busy scoreboard and optional write-to-read bypass
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i,
  input  logic              claim_en_i,
  input  logic [AW-1:0]     claim_addr_i,
  input  logic              flush_i,
  output logic [AW:0]       busy_cnt_o,
  output logic              any_busy_o
);
  logic [XLEN-1:0] mem [1:NREGS-1];
  logic [NREGS-1:1] busy_q, busy_d;
  logic [AW:0] cnt_d;
  logic wr_hit, claim_hit;
  assign wr_hit = wr_en_i && wr_addr_i != '0;
  assign claim_hit = claim_en_i && claim_addr_i != '0;
  assign any_busy_o = busy_cnt_o != '0;
  // later assignments win: claim over flush over write
  always_comb begin
    busy_d = busy_q;
    if (wr_hit) busy_d[wr_addr_i] = 1'b0;
    if (flush_i) busy_d = '0;
    if (claim_hit) busy_d[claim_addr_i] = 1'b1;
    cnt_d = '0;
    for (int k = 1; k < NREGS; k++) cnt_d = cnt_d + (AW+1)'(busy_d[k]);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      busy_cnt_o <= '0;
      for (int k = 1; k < NREGS; k++) mem[k] <= '0;
    end else begin
      busy_q <= busy_d;
      busy_cnt_o <= cnt_d;
      if (wr_hit) mem[wr_addr_i] <= wr_data_i;
    end
  end
  // bypass is gated by reset so reads stay zero while rst_ni is low
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic byp;
    assign a = rd_addr_i[p*AW +: AW];
    assign byp = BYPASS != 0 && rst_ni && wr_hit && wr_addr_i == a;
    assign rd_data_o[p*XLEN +: XLEN] = a == '0 ? '0 : byp ? wr_data_i : mem[a];
    assign rd_busy_o[p] = a != '0 && !byp && busy_q[a];
  end
endmodule
